// File: rtl/force_pkg.sv
// Shared definitions for the force-measurement frame transmitter.
//   SYNC_BYTE_DEF : default first byte of every frame
//   UART_START/STOP : 8N1 framing bit levels
//   state_t       : framer FSM states
//   frame_len()   : bytes per frame for a given channel count
package force_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic       UART_START    = 1'b0;
    localparam logic       UART_STOP     = 1'b1;

    typedef enum logic [1:0] {
        CAPTURE,
        DISCARD,
        SEND,
        WAIT_BIT
    } state_t;

    // Sync byte + sequence byte + two bytes per channel + checksum.
    function automatic int frame_len(input int num_ch);
        return 3 + 2 * num_ch;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter for one byte at a time.
//   clk        : system clock, rising edge
//   switch_rst : asynchronous active-high reset, forces the line idle
//   data       : byte to send, sampled when load is high
//   load       : start a byte; honoured while idle or in the last stop-bit cycle
//   tx         : serial line, idle high
//   done       : one-cycle pulse during the final cycle of the stop bit
module uart_tx_8n1
    import force_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1154
) (
    input  logic       clk,
    input  logic       switch_rst,
    input  logic [7:0] data,
    input  logic       load,
    output logic       tx,
    output logic       done
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;  // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       shift;
    logic             active;

    // Loading in the stop bit's last cycle chains bytes with no idle gap.
    assign done = active && (bit_idx == 4'd9) && (clk_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge switch_rst) begin
        if (switch_rst) begin
            tx      <= UART_STOP;
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (load) begin
            tx      <= UART_START;
            shift   <= data;
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else if (active) begin
            if (clk_cnt == CNT_LAST) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        tx <= UART_STOP;
                    end else begin
                        tx    <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                    end
                end
            end else begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/force_frame_uart_tx.sv
// Collects NUM_CH 16-bit samples over valid/ready, frames them as
// SYNC, seq, ch0 hi, ch0 lo, ..., checksum and sends the frame as 8N1 UART.
//   clk        : 133 MHz system clock
//   switch_rst : asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready : sample word stream from the ADC stage
//   tx         : UART output, idle high
//   busy       : frame transmission in progress
//   frame_err  : one-cycle pulse when a short or long set is discarded
//   drop_cnt   : words offered while s_ready=0, saturating at 255
//   seq        : sequence number of the next frame
module force_frame_uart_tx
    import force_pkg::*;
#(
    parameter int         NUM_CH       = 8,
    parameter int         CLKS_PER_BIT = 1154,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        switch_rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        tx,
    output logic        busy,
    output logic        frame_err,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  seq
);

    localparam int NBYTES = frame_len(NUM_CH);
    localparam int IDX_W  = $clog2(NUM_CH + 1);
    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BYTE_W = $clog2(NBYTES);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0]  IDX_FULL = IDX_W'(NUM_CH);
    localparam logic [BYTE_W-1:0] CKS_IDX  = BYTE_W'(NBYTES - 1);
    // NBYTES is odd and >= 5, so it always fits in BYTE_W bits.
    localparam logic [BYTE_W-1:0] BYTE_END = BYTE_W'(NBYTES);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] byte_idx;
    logic [7:0]        frame_seq;
    logic [7:0]        data_xor;
    logic [15:0]       samples [2**SLOT_W];

    logic              take;
    logic              load;
    logic              done;
    logic [7:0]        tx_byte;
    logic [BYTE_W-1:0] data_off;
    logic [SLOT_W-1:0] rd_slot;
    logic [15:0]       rd_word;

    assign take = s_valid && s_ready;
    assign load = (state == SEND) || ((state == WAIT_BIT) && done && (byte_idx != BYTE_END));

    // NOTE: the sample buffer has no reset; it is always fully rewritten
    // before a frame reads it, so resetting it would only cost logic.
    always_ff @(posedge clk) begin
        if (take && (state == CAPTURE) && (idx != IDX_FULL))
            samples[idx[SLOT_W-1:0]] <= s_data;
    end

    always_ff @(posedge clk or posedge switch_rst) begin
        if (switch_rst) begin
            state     <= CAPTURE;
            idx       <= '0;
            byte_idx  <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
            seq       <= '0;
            frame_seq <= '0;
            data_xor  <= '0;
        end else begin
            frame_err <= 1'b0;
            if (s_valid && !s_ready && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;

            case (state)
                CAPTURE: begin
                    s_ready <= 1'b1;
                    if (take) begin
                        if (idx == IDX_FULL) begin
                            // Long set: drop the surplus word, then skip to s_last.
                            frame_err <= 1'b1;
                            idx       <= '0;
                            if (!s_last)
                                state <= DISCARD;
                        end else begin
                            data_xor <= ((idx == '0) ? 8'h00 : data_xor) ^ s_data[15:8] ^ s_data[7:0];
                            if (s_last) begin
                                idx <= '0;
                                if (idx == IDX_LAST) begin
                                    state     <= SEND;
                                    frame_seq <= seq;
                                    byte_idx  <= '0;
                                    s_ready   <= 1'b0;
                                    busy      <= 1'b1;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                DISCARD: begin
                    s_ready <= 1'b1;
                    if (take && s_last)
                        state <= CAPTURE;
                end
                SEND: begin
                    state    <= WAIT_BIT;
                    byte_idx <= byte_idx + BYTE_W'(1);
                end
                WAIT_BIT: begin
                    if (done) begin
                        if (byte_idx == BYTE_END) begin
                            state   <= CAPTURE;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                            idx     <= '0;
                            seq     <= seq + 8'd1;
                        end else begin
                            byte_idx <= byte_idx + BYTE_W'(1);
                        end
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

    // Byte selector: byte 2+2c is channel c high byte, 3+2c its low byte.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        tx_byte  = 8'h00;
        data_off = byte_idx - BYTE_W'(2);
        rd_slot  = SLOT_W'(data_off >> 1);
        rd_word  = samples[rd_slot];
        if (byte_idx == '0)
            tx_byte = SYNC_BYTE;
        else if (byte_idx == BYTE_W'(1))
            tx_byte = frame_seq;
        else if (byte_idx == CKS_IDX)
            tx_byte = frame_seq ^ data_xor;
        else
            tx_byte = data_off[0] ? rd_word[7:0] : rd_word[15:8];
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk       (clk),
        .switch_rst(switch_rst),
        .data      (tx_byte),
        .load      (load),
        .tx        (tx),
        .done      (done)
    );

endmodule

// File: tb/tb_force_frame_uart_tx.sv
// Self-checking bench for force_frame_uart_tx.
// Main instance: NUM_CH=8, CLKS_PER_BIT=4. Second instance: NUM_CH=1,
// CLKS_PER_BIT=1, used for the 256-frame sequence wrap.
module tb_force_frame_uart_tx;

    localparam int BUSY_LEN   = 761;  // 19 bytes * 10 bits * 4 clks + 1
    localparam int W_BUSY_LEN = 51;   // 5 bytes * 10 bits * 1 clk + 1

    logic        clk;
    logic        switch_rst;
    logic [15:0] s_data;
    logic        s_valid, s_last;
    logic        s_ready, tx, busy, frame_err;
    logic [7:0]  drop_cnt, seq;

    logic [15:0] w_data;
    logic        w_valid, w_last;
    logic        w_ready, w_tx, w_busy, w_frame_err;
    logic [7:0]  w_drop_cnt, w_seq;

    int n_cmp  = 0;
    int n_fail = 0;
    int stop_err = 0;
    logic [7:0] rx_q [$];
    logic [7:0] rxw_q [$];

    typedef struct {
        logic [15:0] words [8];
        int          extra;   // words offered while the frame is sent
        logic [7:0]  cks;
        logic [7:0]  seq0;
        logic [7:0]  drop;    // drop_cnt after the frame
    } vec_t;
    vec_t vecs [4];

    force_frame_uart_tx #(.NUM_CH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .switch_rst(switch_rst), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .tx(tx), .busy(busy),
        .frame_err(frame_err), .drop_cnt(drop_cnt), .seq(seq)
    );

    force_frame_uart_tx #(.NUM_CH(1), .CLKS_PER_BIT(1)) dut_wrap (
        .clk(clk), .switch_rst(switch_rst), .s_data(w_data), .s_valid(w_valid),
        .s_last(w_last), .s_ready(w_ready), .tx(w_tx), .busy(w_busy),
        .frame_err(w_frame_err), .drop_cnt(w_drop_cnt), .seq(w_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sel_tx(input bit inst);
        return inst ? w_tx : tx;
    endfunction

    // Decodes one 8N1 byte sampled mid-bit on negedges; ok=0 if reset hit it.
    task automatic uart_rx(input bit inst, input int cpb, output logic [7:0] b,
                           output bit ok, output bit stop_bad);
        ok = 1'b1;
        stop_bad = 1'b0;
        b = '0;
        do @(negedge clk); while (switch_rst || sel_tx(inst) !== 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat ((k == 0) ? cpb + (cpb - 1) / 2 : cpb) @(negedge clk);
            if (switch_rst) ok = 1'b0;
            b[k] = sel_tx(inst);
        end
        repeat (cpb) @(negedge clk);
        if (switch_rst) ok = 1'b0;
        if (ok && sel_tx(inst) !== 1'b1) stop_bad = 1'b1;
    endtask

    initial begin : rx_main
        logic [7:0] b;
        bit ok, sb;
        forever begin
            uart_rx(1'b0, 4, b, ok, sb);
            if (sb) stop_err++;
            if (ok) rx_q.push_back(b);
        end
    end

    initial begin : rx_wrap
        logic [7:0] b;
        bit ok, sb;
        forever begin
            uart_rx(1'b1, 1, b, ok, sb);
            if (sb) stop_err++;
            if (ok) rxw_q.push_back(b);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic put_word(input logic [15:0] d, input logic last, output logic err);
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        @(posedge clk);
        #1;
        err     = frame_err;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 100 && !s_ready; i++) @(negedge clk);
        check(name, s_ready, 1'b1);
    endtask

    task automatic run_frame(input string name, input logic [15:0] w [8], input int extra,
                             input logic [7:0] cks, input logic [7:0] seq0, input logic [7:0] drop);
        logic err;
        int busy_cnt;
        logic [7:0] exp [19];
        logic [7:0] nxt;
        wait_ready({name, "_rdy"});
        rx_q.delete();
        for (int c = 0; c < 8; c++) put_word(w[c], c == 7, err);
        check({name, "_err"}, err, 1'b0);
        check({name, "_busy_on"}, busy, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            s_valid = (i >= 2 && i < 2 + extra);
        end
        s_valid = 1'b0;
        check({name, "_busy_len"}, busy_cnt, BUSY_LEN);
        @(negedge clk);
        nxt = seq0 + 8'd1;
        check({name, "_ready"}, s_ready, 1'b1);
        check({name, "_tx_idle"}, tx, 1'b1);
        check({name, "_seq"}, seq, nxt);
        check({name, "_drop"}, drop_cnt, drop);
        exp[0] = 8'hA5;
        exp[1] = seq0;
        for (int c = 0; c < 8; c++) begin
            exp[2 + 2 * c] = w[c][15:8];
            exp[3 + 2 * c] = w[c][7:0];
        end
        exp[18] = cks;
        check({name, "_nbytes"}, rx_q.size(), 19);
        for (int b = 0; b < 19; b++)
            if (rx_q.size() > b) check($sformatf("%s_b%0d", name, b), rx_q[b], exp[b]);
    endtask

    initial begin : main
        logic err;
        logic errs [10];
        logic any_err;
        bit quiet, found;
        int cnt;

        vecs[0].words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                          16'h0005, 16'h0006, 16'h0007, 16'h0008};
        vecs[0].extra = 3;   vecs[0].cks = 8'h08; vecs[0].seq0 = 8'h00; vecs[0].drop = 8'd3;
        vecs[1].words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                          16'h0F0F, 16'hF0F0, 16'hA5A5, 16'h5A5A};
        vecs[1].extra = 0;   vecs[1].cks = 8'h01; vecs[1].seq0 = 8'h01; vecs[1].drop = 8'd3;
        vecs[2].words = '{16'h8000, 16'h0001, 16'h00FF, 16'hFF00,
                          16'h1111, 16'h2222, 16'h4444, 16'h8888};
        vecs[2].extra = 2;   vecs[2].cks = 8'h83; vecs[2].seq0 = 8'h02; vecs[2].drop = 8'd5;
        vecs[3].words = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                          16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3].extra = 300; vecs[3].cks = 8'h03; vecs[3].seq0 = 8'h03; vecs[3].drop = 8'd255;

        switch_rst = 1'b1;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        w_data = '0; w_valid = 1'b0; w_last = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", s_ready, 1'b0);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_drop", drop_cnt, 8'd0);
        check("rst_seq", seq, 8'd0);
        switch_rst = 1'b0;
        #1;
        check("rel_ready_low", s_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rel_ready_high", s_ready, 1'b1);

        // Table-driven frames, including back-pressure drops and the flood
        for (int v = 0; v < 4; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].words, vecs[v].extra,
                      vecs[v].cks, vecs[v].seq0, vecs[v].drop);

        // Short set: 5 words then s_last
        wait_ready("short_rdy");
        for (int c = 0; c < 5; c++) begin
            put_word(16'h0A00 + 16'(c), c == 4, err);
            errs[c] = err;
        end
        check("short_err_mid", errs[3], 1'b0);
        check("short_err_last", errs[4], 1'b1);
        @(posedge clk);
        #1;
        check("short_err_one_pulse", frame_err, 1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("short_quiet", quiet, 1'b1);
        check("short_seq", seq, 8'h04);
        check("short_ready", s_ready, 1'b1);
        run_frame("after_short", vecs[0].words, 0, 8'h0C, 8'h04, 8'd255);

        // Long set: 10 words, s_last on the 10th
        wait_ready("long_rdy");
        rx_q.delete();
        for (int c = 0; c < 10; c++) begin
            put_word(16'h0100 + 16'(c), c == 9, err);
            errs[c] = err;
        end
        any_err = 1'b0;
        for (int c = 0; c < 8; c++) any_err = any_err | errs[c];
        check("long_err_pre", any_err, 1'b0);
        check("long_err_w9", errs[8], 1'b1);
        check("long_err_w10", errs[9], 1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("long_quiet", quiet, 1'b1);
        check("long_no_bytes", rx_q.size(), 0);
        check("long_seq", seq, 8'h05);
        run_frame("after_long", vecs[1].words, 0, 8'h05, 8'h05, 8'd255);

        // Reset during data bit 3 of byte 5 (byte 5 = 8'h02, bit 3 = 0)
        wait_ready("mid_rdy");
        for (int c = 0; c < 8; c++) put_word(vecs[0].words[c], c == 7, err);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_start_seen", found, 1'b1);
        repeat (217) @(negedge clk);
        check("mid_pre_tx", tx, 1'b0);
        switch_rst = 1'b1;
        #1;
        check("mid_tx", tx, 1'b1);
        check("mid_busy", busy, 1'b0);
        check("mid_seq", seq, 8'h00);
        check("mid_ready", s_ready, 1'b0);
        repeat (10) @(negedge clk);
        s_valid = 1'b1;
        switch_rst = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("rel_drop", drop_cnt, 8'd1);
        check("rel_ready", s_ready, 1'b1);
        repeat (60) @(negedge clk);
        run_frame("after_rst", vecs[0].words, 0, 8'h08, 8'h00, 8'd1);

        // Sequence wrap on the NUM_CH=1, CLKS_PER_BIT=1 instance
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 100 && !w_ready; i++) @(negedge clk);
            rxw_q.delete();
            @(negedge clk);
            w_data = 16'hFFFF; w_valid = 1'b1; w_last = 1'b1;
            @(posedge clk);
            #1;
            w_valid = 1'b0; w_last = 1'b0;
            cnt = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (!w_busy) break;
                cnt++;
            end
            if (f == 0 || f == 255) begin
                check($sformatf("wrap%0d_busy_len", f), cnt, W_BUSY_LEN);
                check($sformatf("wrap%0d_nbytes", f), rxw_q.size(), 5);
                if (rxw_q.size() == 5) begin
                    check($sformatf("wrap%0d_sync", f), rxw_q[0], 8'hA5);
                    check($sformatf("wrap%0d_seq", f), rxw_q[1], (f == 0) ? 8'h00 : 8'hFF);
                    check($sformatf("wrap%0d_hi", f), rxw_q[2], 8'hFF);
                    check($sformatf("wrap%0d_lo", f), rxw_q[3], 8'hFF);
                    check($sformatf("wrap%0d_cks", f), rxw_q[4], (f == 0) ? 8'h00 : 8'hFF);
                end
            end
        end
        check("wrap_seq_after", w_seq, 8'h00);
        check("wrap_drop", w_drop_cnt, 8'd0);
        check("stop_bits", stop_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/force_frame_uart_tx.md
Name: force_frame_uart_tx

Overview:
- Downstream consumer of the MAX11046 control stage.
- Collects one conversion set of NUM_CH 16-bit channel samples through a valid/ready word interface.
- Wraps the set in a framed packet and serialises it as 8N1 UART for the host PC logging the force measurements.
- Runs in the 133 MHz OSCH clock domain.

Parameters:
- NUM_CH, 8, samples per frame (1..8).
- CLKS_PER_BIT, 1154, clk cycles per UART bit (133 MHz / 115200); bench uses 4.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock, 133 MHz, rising edge.
- switch_rst  in  1  reset switch_rst, asynchronous, active-high.
- s_data  in  16  sample word from the ADC control stage.
- s_valid  in  1  s_data valid.
- s_last  in  1  qualifies the final word of a conversion set (valid with s_valid).
- s_ready  out  1  block accepts a word this cycle.
- tx  out  1  UART serial output, idle high.
- busy  out  1  frame transmission in progress.
- frame_err  out  1  one-cycle pulse: malformed set discarded.
- drop_cnt  out  8  count of words offered while s_ready=0; saturates at 255.
- seq  out  8  sequence number of the next frame to be sent.

Behaviour:
- Reset values: s_ready=0, tx=1, busy=0, frame_err=0, drop_cnt=0, seq=0, word index=0, FSM=CAPTURE. The first cycle after reset release raises s_ready=1.
- Handshake: a word transfers when s_valid && s_ready on a rising clk edge. s_data/s_last are sampled only then.
- CAPTURE state, s_ready=1:
  - Each transferred word is written to buf[idx]; idx increments.
  - s_last with idx+1==NUM_CH: go to SEND; seq is latched into the frame.
  - s_last with idx+1<NUM_CH (short set): discard, pulse frame_err, idx=0, stay in CAPTURE.
  - Word arriving at idx==NUM_CH without s_last (long set): drop the word, pulse frame_err. Remain discarding until s_last, then idx=0; no frame is sent.
- SEND / WAIT_BIT states: s_ready=0, busy=1.
  - Byte order: SYNC_BYTE, seq, then for ch=0..NUM_CH-1: buf[ch][15:8], buf[ch][7:0], then checksum.
  - Checksum = XOR of seq and all data bytes; SYNC_BYTE excluded.
  - Total bytes = 3+2*NUM_CH (19 at default).
- UART 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each CLKS_PER_BIT cycles.
  - Start bit begins the cycle after the byte is loaded.
  - Next byte starts immediately after the stop bit completes, with no idle gap.
  - Frame duration = (3+2*NUM_CH)*10*CLKS_PER_BIT cycles + 1.
- Frame completion: after the checksum stop bit, seq increments (wraps 255->0), busy=0, idx=0, FSM returns to CAPTURE. s_ready=1 on the next cycle.
- Drop counting: s_valid while s_ready=0 increments drop_cnt, saturating at 255. This applies during SEND and during the reset-release cycle. The upstream ADC stage cannot stall, so these words are lost.
- Simultaneous events: a frame_err pulse and a drop_cnt increment may occur in the same cycle; both take effect.
- Reset mid-operation: asserting switch_rst during a byte forces tx=1 immediately (asynchronous). The partial frame is abandoned, seq returns to 0, and the next frame starts cleanly after release.
- Widths: the bit-timer counter is sized by clog2(CLKS_PER_BIT); the byte index counter by clog2(3+2*NUM_CH).

Decomposition:
- Shared package force_pkg: SYNC_BYTE default, UART frame bit constants (START=0, STOP=1), the FSM state enum (CAPTURE, DISCARD, SEND, WAIT_BIT), and a function for frame length 3+2*NUM_CH.
- One sub-module uart_tx_8n1: ports clk, switch_rst, data[7:0], load, tx, done. Parameter CLKS_PER_BIT. done pulses one cycle at the end of the stop bit.
- The framer FSM, sample buffer and checksum live in the top of this block.

Test Plan:
- Nominal frame: CLKS_PER_BIT=4, NUM_CH=8, words 16'h0001..16'h0008 with s_last on the 8th -> tx decodes A5 00 00 01 00 02 ... 00 08 08, then checksum = XOR(00,01..08) = 08. busy high for exactly 761 cycles. seq becomes 1 and s_ready returns to 1.
- Back-pressure drop: offer 3 extra valid words while busy -> drop_cnt=3, frame bytes unchanged. A 300-word flood during SEND saturates drop_cnt at 255.
- Short set: 5 words then s_last -> frame_err one pulse, tx stays 1, seq stays 0. The following 8-word set transmits normally with seq=00.
- Long set: 10 words, s_last on the 10th -> frame_err pulse on word 9, no frame sent. The next correct set sends with the proper data.
- Wrap-around: send 256 frames of 16'hFFFF -> the 256th frame carries seq=FF and checksum FF. Afterwards seq=00.
- Reset mid-byte: assert switch_rst during the data bit 3 of byte 5 -> tx=1 within the same cycle, busy=0, seq=0. A new set after release produces a complete frame starting with A5 00.
